// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock and its code programmer.
// State encoding, phase codes and the factory default unlock code.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VERIFY  = 3'd1,
    ST_NEW     = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  localparam logic [1:0] PHASE_IDLE    = 2'd0;
  localparam logic [1:0] PHASE_VERIFY  = 2'd1;
  localparam logic [1:0] PHASE_NEW     = 2'd2;
  localparam logic [1:0] PHASE_CONFIRM = 2'd3;

  localparam int CODE_W         = 24;
  localparam int BYTES_PER_CODE = 3;

  localparam logic [CODE_W-1:0] LOCK_DEFAULT_CODE = 24'hFF00FF;

  // COMMIT and FAIL are not entry phases, so the display shows IDLE there.
  function automatic logic [1:0] phase_of(state_t s);
    case (s)
      ST_VERIFY:  return PHASE_VERIFY;
      ST_NEW:     return PHASE_NEW;
      ST_CONFIRM: return PHASE_CONFIRM;
      default:    return PHASE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/prog_timeout_timer.sv
// Inactivity timer for the programming phases.
// expire fires on the edge where the count would reach TIMEOUT_CYC-1.
module prog_timeout_timer #(
  parameter int TIMEOUT_CYC = 250000000,
  parameter int TO_W        = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (!en || clr)
      cnt <= '0;
    else
      cnt <= cnt + TO_W'(1);
  end

  // A press in the same cycle clears the count and suppresses expiry.
  assign expire = en && !clr && (cnt == TO_W'(TIMEOUT_CYC - 2));

endmodule

// File: rtl/lock_code_programmer.sv
// Writer side of the 24-bit combination lock: verify old code, enter new
// code twice, then commit it to code_out.
//
// state   | meaning
// IDLE    | waiting for prog_req
// VERIFY  | collecting the current code
// NEW     | collecting the replacement code
// CONFIRM | collecting the replacement code again
// COMMIT  | one cycle, code_out updated
// FAIL    | one cycle, mismatch or timeout reported
module lock_code_programmer
  import lock_pkg::*;
#(
  parameter logic [23:0] DEFAULT_CODE = LOCK_DEFAULT_CODE,
  parameter int          TIMEOUT_CYC  = 250000000,
  parameter int          TO_W         = 28,
  parameter int          MAX_FAILS    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_pulse,
  input  logic [7:0]  code_8bit,
  input  logic        prog_req,
  input  logic        prog_abort,
  output logic [23:0] code_out,
  output logic        prog_busy,
  output logic [1:0]  phase,
  output logic [1:0]  byte_idx,
  output logic        prog_done,
  output logic        prog_fail,
  output logic        prog_timeout,
  output logic        prog_locked
);

  localparam int FC_W = $clog2(MAX_FAILS + 1);

  state_t          state_q, state_d;
  logic [1:0]      idx_d;
  logic [15:0]     cap_q, cap_d;
  logic [23:0]     new_q, new_d;
  logic [23:0]     assembled;
  logic [FC_W-1:0] fail_cnt;
  logic            is_timeout;
  logic            tmr_en, tmr_expire;

  assign tmr_en    = (state_q == ST_VERIFY) || (state_q == ST_NEW) || (state_q == ST_CONFIRM);
  assign assembled = {code_8bit, cap_q};

  prog_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (tmr_en),
    .clr   (btn_pulse | prog_abort),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = byte_idx;
    cap_d      = cap_q;
    new_d      = new_q;
    is_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (prog_req && !prog_locked) begin
          state_d = ST_VERIFY;
          idx_d   = 2'd0;
          cap_d   = '0;
        end
      end
      ST_VERIFY, ST_NEW, ST_CONFIRM: begin
        if (prog_abort) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cap_d   = '0;
          new_d   = '0;
        end else if (tmr_expire) begin
          state_d    = ST_FAIL;
          is_timeout = 1'b1;
          idx_d      = 2'd0;
          cap_d      = '0;
        end else if (btn_pulse) begin
          if (byte_idx < 2'd2) begin
            if (byte_idx == 2'd0) cap_d[7:0]  = code_8bit;
            else                  cap_d[15:8] = code_8bit;
            idx_d = byte_idx + 2'd1;
          end else begin
            idx_d = 2'd0;
            cap_d = '0;
            case (state_q)
              ST_VERIFY: state_d = (assembled == code_out) ? ST_NEW : ST_FAIL;
              ST_NEW: begin
                new_d   = assembled;
                state_d = ST_CONFIRM;
              end
              default:   state_d = (assembled == new_q) ? ST_COMMIT : ST_FAIL;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      byte_idx     <= 2'd0;
      cap_q        <= '0;
      new_q        <= '0;
      code_out     <= DEFAULT_CODE;
      fail_cnt     <= '0;
      prog_locked  <= 1'b0;
      prog_busy    <= 1'b0;
      phase        <= PHASE_IDLE;
      prog_done    <= 1'b0;
      prog_fail    <= 1'b0;
      prog_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx     <= idx_d;
      cap_q        <= cap_d;
      new_q        <= new_d;
      prog_busy    <= (state_d != ST_IDLE);
      phase        <= phase_of(state_d);
      prog_done    <= (state_d == ST_COMMIT);
      prog_fail    <= (state_d == ST_FAIL);
      prog_timeout <= is_timeout;
      if (state_d == ST_COMMIT) begin
        code_out <= new_q;
        fail_cnt <= '0;
      end
      if (state_d == ST_FAIL) begin
        if (fail_cnt != FC_W'(MAX_FAILS)) fail_cnt <= fail_cnt + FC_W'(1);
        if (fail_cnt >= FC_W'(MAX_FAILS - 1)) prog_locked <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lock_code_programmer.sv
// Randomised and directed bench for lock_code_programmer against a
// byte-queue reference model of the programming sequence.
module tb_lock_code_programmer;

  localparam int TIMEOUT_CYC = 20;
  localparam int TO_W        = 5;
  localparam int MAX_FAILS   = 3;
  localparam logic [23:0] DEF = 24'hFF00FF;

  localparam int M_IDLE = 0, M_VERIFY = 1, M_NEW = 2, M_CONFIRM = 3, M_COMMIT = 4, M_FAIL = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_pulse = 1'b0;
  logic [7:0]  code_8bit = 8'h00;
  logic        prog_req = 1'b0;
  logic        prog_abort = 1'b0;
  logic [23:0] code_out;
  logic        prog_busy;
  logic [1:0]  phase;
  logic [1:0]  byte_idx;
  logic        prog_done, prog_fail, prog_timeout, prog_locked;

  lock_code_programmer #(
    .DEFAULT_CODE(DEF),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W),
    .MAX_FAILS   (MAX_FAILS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_pulse   (btn_pulse),
    .code_8bit   (code_8bit),
    .prog_req    (prog_req),
    .prog_abort  (prog_abort),
    .code_out    (code_out),
    .prog_busy   (prog_busy),
    .phase       (phase),
    .byte_idx    (byte_idx),
    .prog_done   (prog_done),
    .prog_fail   (prog_fail),
    .prog_timeout(prog_timeout),
    .prog_locked (prog_locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int          m_mode;
  logic [7:0]  m_q[$];
  logic [23:0] m_code, m_new;
  int          m_fails, m_idle;
  bit          m_locked, e_done, e_fail, e_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_q.delete(); m_code = DEF; m_new = '0;
    m_fails = 0; m_idle = 0; m_locked = 0; e_done = 0; e_fail = 0; e_to = 0;
  endtask

  task automatic model_fail(input bit timeout);
    m_mode = M_FAIL; e_fail = 1; e_to = timeout;
    if (m_fails < MAX_FAILS) m_fails++;
    if (m_fails >= MAX_FAILS) m_locked = 1;
  endtask

  task automatic model_step(input bit btn, input logic [7:0] b, input bit rq, input bit ab);
    logic [23:0] val;
    e_done = 0; e_fail = 0; e_to = 0;
    case (m_mode)
      M_IDLE: if (rq && !m_locked) begin m_mode = M_VERIFY; m_q.delete(); m_idle = 0; end
      M_COMMIT, M_FAIL: m_mode = M_IDLE;
      default: begin
        if (ab) begin
          m_mode = M_IDLE; m_q.delete();
        end else if (btn) begin
          m_idle = 0;
          m_q.push_back(b);
          if (m_q.size() == 3) begin
            val = {m_q[2], m_q[1], m_q[0]};
            m_q.delete();
            if (m_mode == M_VERIFY) begin
              if (val == m_code) m_mode = M_NEW; else model_fail(0);
            end else if (m_mode == M_NEW) begin
              m_new = val; m_mode = M_CONFIRM;
            end else begin
              if (val == m_new) begin
                m_mode = M_COMMIT; m_code = m_new; e_done = 1; m_fails = 0;
              end else model_fail(0);
            end
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT_CYC - 1) begin m_q.delete(); model_fail(1); end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    bit entering;
    entering = (m_mode == M_VERIFY) || (m_mode == M_NEW) || (m_mode == M_CONFIRM);
    chk("code_out", code_out, m_code);
    chk("busy", prog_busy, m_mode != M_IDLE);
    chk("phase", phase, entering ? m_mode : 0);
    chk("byte_idx", byte_idx, entering ? m_q.size() : 0);
    chk("done", prog_done, e_done);
    chk("fail", prog_fail, e_fail);
    chk("timeout", prog_timeout, e_to);
    chk("locked", prog_locked, m_locked);
  endtask

  task automatic step(input bit btn, input logic [7:0] b, input bit rq, input bit ab);
    btn_pulse = btn; code_8bit = b; prog_req = rq; prog_abort = ab;
    @(posedge clk);
    model_step(btn, b, rq, ab);
    #1;
    compare_all();
  endtask

  task automatic press(input logic [7:0] b);
    step(1, b, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; btn_pulse = 0; prog_req = 0; prog_abort = 0; code_8bit = 8'h00;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  function automatic logic [7:0] pick_byte(int pct_good);
    logic [23:0] ref_v;
    int k;
    k = m_q.size();
    if (k > 2) k = 2;
    ref_v = (m_mode == M_CONFIRM) ? m_new : m_code;
    if ((m_mode == M_VERIFY || m_mode == M_CONFIRM) && $urandom_range(0, 99) < pct_good)
      return ref_v[8*k +: 8];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int dens;
    bit b, rq, ab;

    do_reset();
    chk("rst_code", code_out, 24'hFF00FF);
    chk("rst_busy", prog_busy, 0);

    // happy path
    step(0, 8'h00, 1, 0);
    press(8'hFF); press(8'h00); press(8'hFF);
    press(8'h12); press(8'h34); press(8'h56);
    press(8'h12); press(8'h34); press(8'h56);
    chk("happy_done", prog_done, 1);
    chk("happy_code", code_out, 24'h563412);
    idle(1);
    chk("happy_done_gone", prog_done, 0);
    chk("happy_busy", prog_busy, 0);

    // wrong verify
    do_reset();
    step(0, 8'h00, 1, 0);
    press(8'hFF); press(8'h01); press(8'hFF);
    chk("wv_fail", prog_fail, 1);
    idle(1);
    chk("wv_code", code_out, 24'hFF00FF);
    chk("wv_phase", phase, 0);

    // confirm mismatch
    step(0, 8'h00, 1, 0);
    press(8'hFF); press(8'h00); press(8'hFF);
    press(8'h11); press(8'h22); press(8'h33);
    press(8'h11); press(8'h22); press(8'h34);
    chk("cm_fail", prog_fail, 1);
    chk("cm_code", code_out, 24'hFF00FF);
    idle(1);

    // timeout after 19 idle cycles
    do_reset();
    step(0, 8'h00, 1, 0);
    press(8'hAA);
    idle(18);
    chk("to_early", prog_fail, 0);
    idle(1);
    chk("to_fail", prog_fail, 1);
    chk("to_flag", prog_timeout, 1);
    idle(1);

    // press on cycle 19 beats the timeout
    step(0, 8'h00, 1, 0);
    press(8'hAA);
    idle(18);
    press(8'hBB);
    chk("to_press_fail", prog_fail, 0);
    chk("to_press_idx", byte_idx, 2);
    step(0, 8'h00, 0, 1);

    // abort mid-NEW, then coincident req and press
    step(0, 8'h00, 1, 0);
    press(8'hFF); press(8'h00); press(8'hFF);
    press(8'h11);
    step(0, 8'h00, 0, 1);
    chk("abort_fail", prog_fail, 0);
    chk("abort_phase", phase, 0);
    step(1, 8'h77, 1, 0);
    chk("req_btn_phase", phase, 1);
    chk("req_btn_idx", byte_idx, 0);
    step(0, 8'h00, 0, 1);

    // one fail already recorded by the timeout; two more wrong verifies lock
    step(0, 8'h00, 1, 0);
    press(8'h01); press(8'h02); press(8'h03);
    idle(1);
    chk("lock_not_yet", prog_locked, 0);
    step(0, 8'h00, 1, 0);
    press(8'h01); press(8'h02); press(8'h03);
    idle(1);
    chk("lock_set", prog_locked, 1);
    step(0, 8'h00, 1, 0);
    idle(1);
    chk("lock_req_phase", phase, 0);
    do_reset();
    chk("lock_cleared", prog_locked, 0);

    // randomised traffic
    for (int seg = 0; seg < 30; seg++) begin
      dens = $urandom_range(3, 50);
      for (int c = 0; c < 200; c++) begin
        b  = ($urandom_range(0, 99) < dens);
        rq = ($urandom_range(0, 19) == 0);
        ab = ($urandom_range(0, 149) == 0);
        step(b, pick_byte(85), rq, ab);
      end
      if (m_locked && $urandom_range(0, 1) == 1) do_reset();
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
